// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
//   Source-domain half of a 4-phase REQ/ACK handshake that carries one
//   WIDTH-bit word per transfer into a foreign clock domain.
//
//   Handshake: a transfer is accepted when SEND is high in IDLE. DATA_OUT and
//   REQ rise together. DATA_OUT is held until the next accepted SEND. The
//   receiver raises ACK_ASYNC after it has captured DATA_OUT. REQ then drops,
//   and the receiver drops ACK_ASYNC. DONE pulses once ACK is seen low again.
//   SEND is ignored while BUSY is high.
//
//   Optional feature (macro CDC_TX_TIMEOUT_EN): if the FSM spends
//   TIMEOUT_CYCLES cycles in WAIT_HI, it drops REQ and pulses ERR. It then
//   waits in ABORT until ACK is low before it returns to IDLE.
//   In the default build ERR is tied to 0.
//
// Ports
//   CLK        in   source-domain clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   SEND       in   transfer request strobe
//   DATA_IN    in   [WIDTH] word captured on the accepting edge
//   ACK_ASYNC  in   receiver acknowledge, asynchronous to CLK
//   REQ        out  registered request to the receiver
//   DATA_OUT   out  [WIDTH] registered word
//   BUSY       out  transfer in progress
//   DONE       out  one-cycle pulse on completion
//   ERR        out  one-cycle pulse on timeout abort
//   STATE_DBG  out  [2] FSM state (0 IDLE, 1 WAIT_HI, 2 WAIT_LO, 3 ABORT)
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
  parameter int WIDTH          = 16,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SEND,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             ACK_ASYNC,
  output logic             REQ,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [1:0]       STATE_DBG
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cdc_handshake_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

`ifdef CDC_TX_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    ABORT   = 2'd3
  } state_t;

  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  // The abort edge is the TIMEOUT_CYCLES-th edge spent in WAIT_HI.
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;
  logic          err_q;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;
`endif

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // ACK synchronizer. Only the last stage is allowed to reach the FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ACK_ASYNC};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      REQ      <= 1'b0;
      DATA_OUT <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
      err_q    <= 1'b0;
      to_cnt   <= '0;
`endif
    end else begin
      DONE  <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (SEND) begin
            DATA_OUT <= DATA_IN;
            REQ      <= 1'b1;
            BUSY     <= 1'b1;
            state    <= WAIT_HI;
`ifdef CDC_TX_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        WAIT_HI: begin
          // A real ACK wins over a timeout on the same edge.
          if (ack_s) begin
            REQ   <= 1'b0;
            state <= WAIT_LO;
          end
`ifdef CDC_TX_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            REQ   <= 1'b0;
            err_q <= 1'b1;
            state <= ABORT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_LO: begin
          if (!ack_s) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end
`ifdef CDC_TX_TIMEOUT_EN
        ABORT: begin
          // A late ACK may still arrive. Wait until it is low so the next
          // transfer starts from a clean 4-phase state.
          if (!ack_s) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign STATE_DBG = state;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_handshake_tx
//   Directed bench for cdc_handshake_tx with default WIDTH=16 and SYNC_STAGES=3.
//   The receiver model drives ACK_ASYNC in one of three ways:
//     mode 0 : driven directly by the stimulus
//     mode 1 : immediate echo of REQ
//     mode 2 : REQ delayed by two CLK cycles
//   The timeout steps are built only when CDC_TX_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_cdc_handshake_tx;

  localparam int W = 16;
  localparam int S = 3;
`ifdef CDC_TX_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         send;
  logic [W-1:0] data_in;
  logic         ack_async;
  logic         req;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .SEND      (send),
    .DATA_IN   (data_in),
    .ACK_ASYNC (ack_async),
    .REQ       (req),
    .DATA_OUT  (data_out),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err),
    .STATE_DBG (state_dbg)
  );

  // ---------------- receiver model ----------------
  int         rx_mode = 0;
  logic       ack_man = 1'b0;
  logic [1:0] req_d   = 2'b00;

  always @(posedge clk) req_d <= {req_d[0], req};

  assign ack_async = (rx_mode == 1) ? req :
                     (rx_mode == 2) ? req_d[1] : ack_man;

  // Pulse counters. They read the pre-edge value, so each pulse counts once.
  int done_cnt = 0;
  int err_cnt  = 0;
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of ticks until DONE is seen, or 0 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic start_xfer(input logic [W-1:0] d);
    send    = 1'b1;
    data_in = d;
    tick();
    send    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int           lat;
  int           d0, dc0, ec0;
  int           done_t[3];
  int           nd;
  int           viol;
  logic [W-1:0] prev_dout;
  logic         prev_req;

  initial begin
    rst_n   = 1'b0;
    send    = 1'b0;
    data_in = '0;
    tick();
    tick();
    // Reset state
    chk("rst_req",   32'(req),       32'd0);
    chk("rst_dout",  32'(data_out),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // A short ACK glitch between edges is never sampled
    rx_mode = 0;
    #2 ack_man = 1'b1;
    #2 ack_man = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("glitch_req",   32'(req),       32'd0);
    chk("glitch_state", 32'(state_dbg), 32'd0);
    chk("glitch_busy",  32'(busy),      32'd0);

    // Basic transfer with the receiver responding two cycles later
    rx_mode = 2;
    dc0 = done_cnt;
    start_xfer(16'hA5C3);
    chk("t1_dout", 32'(data_out), 32'h0000A5C3);
    chk("t1_req",  32'(req),      32'd1);
    chk("t1_busy", 32'(busy),     32'd1);
    wait_done(lat);
    // Latency: 2 cycles of echo delay on each edge, plus 2*S+2 cycles.
    chk("t1_latency", 32'(lat), 32'd12);
    chk("t1_dout_hold", 32'(data_out), 32'h0000A5C3);
    tick();
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - dc0), 32'd1);

    // SEND while BUSY is ignored
    rx_mode = 1;
    dc0 = done_cnt;
    start_xfer(16'h00FF);
    tick();
    tick();
    send    = 1'b1;
    data_in = 16'h1111;
    tick();
    send    = 1'b0;
    chk("t2_dout_busy", 32'(data_out), 32'h000000FF);
    wait_done(lat);
    chk("t2_latency_rest", 32'(lat), 32'(2*S+2-3));
    chk("t2_dout_after", 32'(data_out), 32'h000000FF);
    for (int i = 0; i < 12; i++) tick();
    chk("t2_done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("t2_busy",     32'(busy), 32'd0);

    // SEND held high with DATA_IN incrementing every cycle.
    // Accepts happen at ticks 1, 10 and 19, and DONE follows at 9, 18 and 27.
    nd = 0;
    viol = 0;
    prev_dout = data_out;
    prev_req  = req;
    send    = 1'b1;
    data_in = 16'h0100;
    for (int t = 1; t <= 27; t++) begin
      tick();
      data_in = W'(16'h0100 + t);
      if (done && nd < 3) begin
        done_t[nd] = t;
        nd++;
      end
      if (data_out !== prev_dout && !(req && !prev_req)) viol++;
      if (t == 1)  chk("t3_dout_1", 32'(data_out), 32'h00000100);
      if (t == 10) chk("t3_dout_2", 32'(data_out), 32'h00000109);
      if (t == 19) chk("t3_dout_3", 32'(data_out), 32'h00000112);
      prev_dout = data_out;
      prev_req  = req;
    end
    send = 1'b0;
    chk("t3_ndone",  32'(nd), 32'd3);
    chk("t3_done_0", 32'(done_t[0]), 32'd9);
    chk("t3_done_1", 32'(done_t[1]), 32'd18);
    chk("t3_done_2", 32'(done_t[2]), 32'd27);
    chk("t3_dout_stable", 32'(viol), 32'd0);
    tick();
    tick();

    // Reset pulse during WAIT_LO
    dc0 = done_cnt;
    ec0 = err_cnt;
    start_xfer(16'hBEEF);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_state_wlo", 32'(state_dbg), 32'd2);
    chk("t4_req_wlo",   32'(req),       32'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_dout",  32'(data_out),  32'd0);
    chk("t4_rst_busy",  32'(busy),      32'd0);
    chk("t4_rst_state", 32'(state_dbg), 32'd0);
    chk("t4_rst_req",   32'(req),       32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("t4_no_err",  32'(err_cnt - ec0),  32'd0);
    start_xfer(16'h1234);
    chk("t4_next_dout", 32'(data_out), 32'h00001234);
    wait_done(lat);
    chk("t4_next_latency", 32'(lat), 32'(2*S+2));
    tick();

`ifdef CDC_TX_TIMEOUT_EN
    // Timeout with the receiver silent
    rx_mode = 0;
    ack_man = 1'b0;
    dc0 = done_cnt;
    start_xfer(16'hCAFE);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err) begin
        lat = k;
        break;
      end
    end
    chk("to_latency", 32'(lat), 32'd8);
    chk("to_req",     32'(req),  32'd0);
    chk("to_busy_hi", 32'(busy), 32'd1);
    tick();
    chk("to_err_low", 32'(err),       32'd0);
    chk("to_busy_lo", 32'(busy),      32'd0);
    chk("to_state",   32'(state_dbg), 32'd0);
    chk("to_no_done", 32'(done_cnt - dc0), 32'd0);
`else
    chk("no_err_ever", 32'(err_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
